// File: rtl/fpu_share_if.sv
`default_nettype none
// ============================================================================
// Module      : fpu_share_if
// Description : One requester port of the shared-FPU sequencer. Carries the
//               operand request handshake and the result response handshake.
//               master = requester side, slave = fpu_share_ctrl side.
//   req_valid/req_ready   : request handshake
//   req_a/req_b           : 32-bit operands
//   req_ctrl              : 4-bit FPU opcode
//   req_rs2_0             : signed/unsigned convert select
//   resp_valid/resp_ready : response handshake
//   resp_data             : 32-bit result
// Revision    : 1.0  initial release
// ============================================================================
interface fpu_share_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  req_ctrl;
  logic        req_rs2_0;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;

  modport master (
    output req_valid, req_a, req_b, req_ctrl, req_rs2_0, resp_ready,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_a, req_b, req_ctrl, req_rs2_0, resp_ready,
    output req_ready, resp_valid, resp_data
  );
endinterface
`default_nettype wire

// File: rtl/fpu_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fpu_share_ctrl
// Description : Sequencer and two-way round-robin arbiter sharing one
//               combinational single-precision FPU between port 0 (integer
//               pipeline FP execute) and port 1 (FP coprocessor / load
//               convert). An accepted request's operands are registered onto
//               the FPU inputs, held for LATENCY settle cycles, and the result
//               is captured into a response register held until taken.
//               Port 0 transactions are cancelled by flush.
//   clk, rst_n        : clock, asynchronous active-low reset
//   p0, p1            : requester ports (fpu_share_if.slave)
//   flush             : cancel any port 0 transaction
//   fpu_a/b/ctrl/rs2_0: operand register driving the FPU
//   fpu_out           : FPU result
//   busy              : controller not idle
// Revision    : 1.0  initial release
// ============================================================================
module fpu_share_ctrl #(
  parameter int LATENCY = 1   // settle cycles, legal 1..15
) (
  input  wire          clk,
  input  wire          rst_n,
  fpu_share_if.slave   p0,
  fpu_share_if.slave   p1,
  input  wire          flush,
  output logic [31:0]  fpu_a,
  output logic [31:0]  fpu_b,
  output logic [3:0]   fpu_ctrl,
  output logic         fpu_rs2_0,
  input  wire  [31:0]  fpu_out,
  output logic         busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [3:0] C_CNT_INIT = 4'(LATENCY - 1);

  logic [1:0]  r_state;
  logic [1:0]  w_next_state;
  logic [3:0]  r_cnt;
  logic        r_owner;
  logic        r_last;
  logic [31:0] r_op_a;
  logic [31:0] r_op_b;
  logic [3:0]  r_op_ctrl;
  logic        r_op_rs2_0;
  logic [31:0] r_result;

  logic w_v0;
  logic w_v1;
  logic w_grant;
  logic w_accept;
  logic w_flush_own;
  logic w_resp_take;

  // Flush masks port 0 from arbitration so a redirected request is never
  // started. Grant is only meaningful while at least one valid is present.
  assign w_v0        = p0.req_valid & ~flush;
  assign w_v1        = p1.req_valid;
  assign w_grant     = (w_v0 & w_v1) ? ~r_last : w_v1;
  assign w_accept    = (r_state == S_IDLE) & (w_v0 | w_v1);
  assign w_flush_own = flush & ~r_owner & (r_state != S_IDLE);
  assign w_resp_take = (r_state == S_RESP) &
                       (r_owner ? p1.resp_ready : p0.resp_ready);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; a flush of a port 0 transaction beats both result
  // capture and the response handshake.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next_state = S_EXEC;
      S_EXEC: begin
        if (w_flush_own)       w_next_state = S_IDLE;
        else if (r_cnt == 4'd0) w_next_state = S_RESP;
      end
      S_RESP: begin
        if (w_flush_own || w_resp_take) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Outputs: ready has no path from fpu_out or resp_ready.
  always_comb begin
    p0.req_ready  = (r_state == S_IDLE) & w_v0 & ~w_grant;
    p1.req_ready  = (r_state == S_IDLE) & w_v1 &  w_grant;
    p0.resp_valid = (r_state == S_RESP) & ~r_owner;
    p1.resp_valid = (r_state == S_RESP) &  r_owner;
    p0.resp_data  = r_result;
    p1.resp_data  = r_result;
    busy          = (r_state != S_IDLE);
  end

  assign fpu_a     = r_op_a;
  assign fpu_b     = r_op_b;
  assign fpu_ctrl  = r_op_ctrl;
  assign fpu_rs2_0 = r_op_rs2_0;

  // Operand register, ownership, settle counter and result register.
  // Operands are only loaded on accept, so they stay put in IDLE too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= 4'd0;
      r_owner    <= 1'b0;
      r_last     <= 1'b1;
      r_op_a     <= 32'd0;
      r_op_b     <= 32'd0;
      r_op_ctrl  <= 4'd0;
      r_op_rs2_0 <= 1'b0;
      r_result   <= 32'd0;
    end else begin
      if (w_accept) begin
        r_op_a     <= w_grant ? p1.req_a     : p0.req_a;
        r_op_b     <= w_grant ? p1.req_b     : p0.req_b;
        r_op_ctrl  <= w_grant ? p1.req_ctrl  : p0.req_ctrl;
        r_op_rs2_0 <= w_grant ? p1.req_rs2_0 : p0.req_rs2_0;
        r_owner    <= w_grant;
        r_last     <= w_grant;
        r_cnt      <= C_CNT_INIT;
      end else if (r_state == S_EXEC && !w_flush_own) begin
        if (r_cnt == 4'd0) begin
          r_result <= fpu_out;
        end else begin
          r_cnt <= r_cnt - 4'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fpu_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpu_share_ctrl
// Description : Self-checking bench for fpu_share_ctrl. Two instances:
//               LATENCY=1 (main) and LATENCY=4 (settle timing). A stand-in
//               FPU returns fixed IEEE results for the test operands and a
//               simple XOR signature otherwise; opcodes 13..15 return 0.
// Revision    : 1.0  initial release
// ============================================================================
module tb_fpu_share_ctrl;

  logic clk;
  logic rst_n;
  logic flush;

  int checks;
  int errors;

  fpu_share_if if0 ();
  fpu_share_if if1 ();
  fpu_share_if q0 ();
  fpu_share_if q1 ();

  logic [31:0] fa1, fb1, fo1, fa4, fb4, fo4;
  logic [3:0]  fc1, fc4;
  logic        fr1, fr4, busy1, busy4;

  function automatic logic [31:0] fake_fpu(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] c, input logic r);
    if (c >= 4'd13)                                      return 32'h0;
    if (c == 4'd0 && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    if (c == 4'd12 && a == 32'h00000005)                 return 32'h40A00000;
    return a ^ b ^ {28'd0, c} ^ {31'd0, r};
  endfunction

  assign fo1 = fake_fpu(fa1, fb1, fc1, fr1);
  assign fo4 = fake_fpu(fa4, fb4, fc4, fr4);

  fpu_share_ctrl #(.LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .p0(if0.slave), .p1(if1.slave), .flush(flush),
    .fpu_a(fa1), .fpu_b(fb1), .fpu_ctrl(fc1), .fpu_rs2_0(fr1),
    .fpu_out(fo1), .busy(busy1)
  );

  fpu_share_ctrl #(.LATENCY(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .p0(q0.slave), .p1(q1.slave), .flush(1'b0),
    .fpu_a(fa4), .fpu_b(fb4), .fpu_ctrl(fc4), .fpu_rs2_0(fr4),
    .fpu_out(fo4), .busy(busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Requester rule: operands stable while valid && !ready.
  logic        h0, h1;
  logic [68:0] s0, s1;
  always @(posedge clk) begin
    if (rst_n && h0 && if0.req_valid &&
        {if0.req_a, if0.req_b, if0.req_ctrl, if0.req_rs2_0} !== s0) begin
      errors = errors + 1;
      $display("FAIL p0 operand stability: got %h expected %h",
               {if0.req_a, if0.req_b, if0.req_ctrl, if0.req_rs2_0}, s0);
    end
    if (rst_n && h1 && if1.req_valid &&
        {if1.req_a, if1.req_b, if1.req_ctrl, if1.req_rs2_0} !== s1) begin
      errors = errors + 1;
      $display("FAIL p1 operand stability: got %h expected %h",
               {if1.req_a, if1.req_b, if1.req_ctrl, if1.req_rs2_0}, s1);
    end
    h0 <= rst_n && if0.req_valid && !if0.req_ready;
    h1 <= rst_n && if1.req_valid && !if1.req_ready;
    s0 <= {if0.req_a, if0.req_b, if0.req_ctrl, if0.req_rs2_0};
    s1 <= {if1.req_a, if1.req_b, if1.req_ctrl, if1.req_rs2_0};
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        v0, v1;
    logic        rdy0, rdy1, rv0, rv1, busy;
    logic [31:0] data;
  } vec_t;

  vec_t tbl [18];

  task automatic p0_add();
    if0.req_a = 32'h3F800000; if0.req_b = 32'h40000000; if0.req_ctrl = 4'd0;
  endtask

  task automatic p1_cvt();
    if1.req_a = 32'h00000005; if1.req_b = 32'h0; if1.req_ctrl = 4'd12;
  endtask

  initial begin
    checks = 0; errors = 0;
    h0 = 1'b0; h1 = 1'b0; s0 = '0; s1 = '0;
    rst_n = 1'b0; flush = 1'b0;
    if0.req_valid = 0; if0.req_a = 0; if0.req_b = 0; if0.req_ctrl = 0; if0.req_rs2_0 = 0;
    if1.req_valid = 0; if1.req_a = 0; if1.req_b = 0; if1.req_ctrl = 0; if1.req_rs2_0 = 1;
    q0.req_valid = 0;  q0.req_a = 0;  q0.req_b = 0;  q0.req_ctrl = 0;  q0.req_rs2_0 = 0;
    q1.req_valid = 0;  q1.req_a = 0;  q1.req_b = 0;  q1.req_ctrl = 0;  q1.req_rs2_0 = 0;
    if0.resp_ready = 1; if1.resp_ready = 1; q0.resp_ready = 1; q1.resp_ready = 1;

    // Alternating grants: each op is EXEC then RESP, then next IDLE grant.
    for (int k = 0; k < 6; k++) begin
      logic port;
      logic [31:0] prev, res;
      port = k[0];
      res  = port ? 32'h40A00000 : 32'h40400000;
      prev = (k == 0) ? 32'h0 : (port ? 32'h40400000 : 32'h40A00000);
      tbl[3*k]   = '{v0:1, v1:1, rdy0:!port, rdy1:port, rv0:0, rv1:0, busy:0, data:prev};
      tbl[3*k+1] = '{v0:1, v1:1, rdy0:0, rdy1:0, rv0:0, rv1:0, busy:1, data:prev};
      tbl[3*k+2] = '{v0:1, v1:1, rdy0:0, rdy1:0, rv0:!port, rv1:port, busy:1, data:res};
    end

    // Reset state
    #12;
    chk("rst busy", 32'(busy1), 32'd0);
    chk("rst p0 ready", 32'(if0.req_ready), 32'd0);
    chk("rst p1 ready", 32'(if1.req_ready), 32'd0);
    chk("rst p0 rv", 32'(if0.resp_valid), 32'd0);
    chk("rst p1 rv", 32'(if1.resp_valid), 32'd0);
    chk("rst data", if0.resp_data, 32'h0);
    chk("rst fpu_a", fa1, 32'h0);
    tick();
    rst_n = 1'b1;

    // Table: both ports valid every cycle, resp_ready high
    p0_add(); p1_cvt();
    for (int i = 0; i < 18; i++) begin
      if0.req_valid = tbl[i].v0;
      if1.req_valid = tbl[i].v1;
      #1;
      chk($sformatf("tbl[%0d] p0 ready", i), 32'(if0.req_ready), 32'(tbl[i].rdy0));
      chk($sformatf("tbl[%0d] p1 ready", i), 32'(if1.req_ready), 32'(tbl[i].rdy1));
      chk($sformatf("tbl[%0d] p0 rv", i), 32'(if0.resp_valid), 32'(tbl[i].rv0));
      chk($sformatf("tbl[%0d] p1 rv", i), 32'(if1.resp_valid), 32'(tbl[i].rv1));
      chk($sformatf("tbl[%0d] busy", i), 32'(busy1), 32'(tbl[i].busy));
      chk($sformatf("tbl[%0d] data", i), if1.resp_data, tbl[i].data);
      tick();
    end
    if0.req_valid = 0; if1.req_valid = 0;

    // Backpressure on port 1 with port 0 waiting
    if1.resp_ready = 0; if1.req_valid = 1;
    #1;
    chk("bp p1 ready", 32'(if1.req_ready), 32'd1);
    chk("bp p0 ready idle", 32'(if0.req_ready), 32'd0);
    tick();
    if1.req_valid = 0; if0.req_valid = 1;
    #1;
    chk("bp exec p0 ready", 32'(if0.req_ready), 32'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("bp hold %0d p1 rv", i), 32'(if1.resp_valid), 32'd1);
      chk($sformatf("bp hold %0d data", i), if1.resp_data, 32'h40A00000);
      chk($sformatf("bp hold %0d p0 ready", i), 32'(if0.req_ready), 32'd0);
      tick();
    end
    if1.resp_ready = 1;
    #1;
    chk("bp take p0 ready", 32'(if0.req_ready), 32'd0);
    tick();
    chk("bp after take p0 ready", 32'(if0.req_ready), 32'd1);
    chk("bp after take busy", 32'(busy1), 32'd0);
    tick();
    if0.req_valid = 0;
    tick();
    chk("bp p0 rv", 32'(if0.resp_valid), 32'd1);
    chk("bp p0 data", if0.resp_data, 32'h40400000);
    tick();

    // Flush of port 0 in EXEC, pending port 1 accepted next cycle
    if0.req_a = 32'h1; if0.req_b = 32'h2; if0.req_ctrl = 4'd1; if0.req_valid = 1;
    #1;
    chk("fl p0 ready", 32'(if0.req_ready), 32'd1);
    tick();
    if0.req_valid = 0; if1.req_valid = 1; flush = 1;
    #1;
    chk("fl exec busy", 32'(busy1), 32'd1);
    chk("fl exec p1 ready", 32'(if1.req_ready), 32'd0);
    tick();
    flush = 0;
    #1;
    chk("fl idle busy", 32'(busy1), 32'd0);
    chk("fl no p0 rv", 32'(if0.resp_valid), 32'd0);
    chk("fl p1 ready", 32'(if1.req_ready), 32'd1);
    chk("fl result kept", if0.resp_data, 32'h40400000);
    tick();
    flush = 1; if1.req_valid = 0;
    #1;
    chk("fl p1 exec busy", 32'(busy1), 32'd1);
    tick();
    flush = 0;
    #1;
    chk("fl p1 rv", 32'(if1.resp_valid), 32'd1);
    chk("fl p1 data", if1.resp_data, 32'h40A00000);
    tick();

    // Opcode 13 forwarded, zero result delivered
    if0.req_a = 32'h7; if0.req_b = 32'h9; if0.req_ctrl = 4'd13; if0.req_valid = 1;
    #1;
    chk("op13 ready", 32'(if0.req_ready), 32'd1);
    tick();
    if0.req_valid = 0;
    chk("op13 fpu_ctrl", 32'(fc1), 32'd13);
    tick();
    chk("op13 rv", 32'(if0.resp_valid), 32'd1);
    chk("op13 data", if0.resp_data, 32'h0);
    tick();

    // Asynchronous reset in EXEC
    p0_add(); if0.req_valid = 1;
    #1;
    chk("ar ready", 32'(if0.req_ready), 32'd1);
    tick();
    if0.req_valid = 0;
    #1;
    chk("ar exec busy", 32'(busy1), 32'd1);
    #1 rst_n = 0;
    #1;
    chk("ar busy", 32'(busy1), 32'd0);
    chk("ar p0 rv", 32'(if0.resp_valid), 32'd0);
    chk("ar fpu_a", fa1, 32'h0);
    chk("ar data", if0.resp_data, 32'h0);
    tick();
    rst_n = 1;
    if0.req_valid = 1;
    #1;
    chk("ar next ready", 32'(if0.req_ready), 32'd1);
    tick();
    if0.req_valid = 0;
    tick();
    chk("ar next rv", 32'(if0.resp_valid), 32'd1);
    chk("ar next data", if0.resp_data, 32'h40400000);
    tick();

    // LATENCY=4 settle timing
    q0.req_a = 32'h11111111; q0.req_b = 32'h22222222; q0.req_ctrl = 4'd2; q0.req_valid = 1;
    #1;
    chk("l4 ready", 32'(q0.req_ready), 32'd1);
    tick();
    q0.req_valid = 0; q0.req_a = 32'hFFFFFFFF; q0.req_b = 32'hFFFFFFFF;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("l4 cyc%0d rv", k), 32'(q0.resp_valid), 32'd0);
      chk($sformatf("l4 cyc%0d fpu_a", k), fa4, 32'h11111111);
      chk($sformatf("l4 cyc%0d fpu_b", k), fb4, 32'h22222222);
      tick();
    end
    chk("l4 rv", 32'(q0.resp_valid), 32'd1);
    chk("l4 data", q0.resp_data, 32'h33333331);
    chk("l4 resp fpu_a", fa4, 32'h11111111);
    tick();
    chk("l4 idle busy", 32'(busy4), 32'd0);
    chk("l4 idle fpu_a", fa4, 32'h11111111);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
